pci_arbiter: RTL and testbench
==============================

Name: pci_arbiter

Overview:
- Central PCI bus arbiter for the device slots (A, B, C, …).
- Takes active-low bus requests from each device and issues one active-low grant at a time using round-robin priority.
- Watches FRAME#/IRDY# to track bus ownership and parks the bus on a default device when no one is requesting.
- Sits beside the devices on the shared bus; drives each device's gnt input from its req output.

Parameters:
- NUM_DEV, 3: number of requesting devices (2..8).
- OWNER_W, 2: width of owner index; must be ≥ clog2(NUM_DEV).
- PARK_DEV, 0: device index that receives the grant when the bus is idle with no requests.
- GNT_TIMEOUT, 16: idle-bus cycles a granted master may take to assert FRAME# before the grant is revoked (≥ 2).

Ports:
- clk  input  1  bus clock; all state updates on rising edge.
- areset  input  1  asynchronous reset, active-high.
- req_n  input  NUM_DEV  per-device bus request, active-low.
- frame_n  input  1  PCI FRAME#, active-low, sampled on rising edge.
- irdy_n  input  1  PCI IRDY#, active-low, sampled on rising edge.
- gnt_n  output  NUM_DEV  per-device grant, active-low, at most one bit low.
- owner  output  OWNER_W  index of the currently granted or parked device.
- bus_busy  output  1  high while the granted master's transaction is in progress.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, any time): gnt_n = all ones, owner = PARK_DEV, bus_busy = 0, timeout = 0, rr_ptr = 0, idle timer = 0, state = SWITCH.
- Bus idle means frame_n = 1 AND irdy_n = 1 (sampled).
- Winner selection: the first low req_n bit searching upward from rr_ptr, wrapping modulo NUM_DEV.
- If no bit is low, the target is PARK_DEV in PARK state.
- Switch rule: a grant never moves directly between devices.
  - Any change of the granted index inserts exactly one SWITCH cycle with gnt_n all ones.
  - Keeping the same index needs no SWITCH.
- States:
  - SWITCH: gnt_n all ones. Next cycle, go to GRANT(winner) if any request is pending, else PARK; owner updates on that transition.
  - PARK: gnt_n[PARK_DEV] = 0.
    - Any request whose winner == PARK_DEV → GRANT with no dead cycle.
    - Any other winner → SWITCH.
    - frame_n sampled low while parked (parked device starts a transaction) → BUSY.
  - GRANT: gnt_n[owner] = 0. The idle timer increments each cycle the bus is idle; it holds otherwise.
    - frame_n sampled low → BUSY, rr_ptr ← (owner+1) mod NUM_DEV, timer cleared.
    - req_n[owner] deasserts before FRAME# → SWITCH (or stay if the re-evaluated winner is the same index).
    - Timer reaches GNT_TIMEOUT → timeout = 1 for one cycle, rr_ptr ← (owner+1) mod NUM_DEV, → SWITCH.
  - BUSY: bus_busy = 1, gnt_n[owner] held low.
    - frame_n sampled high (final data phase) → re-evaluate winner.
    - Winner == owner → GRANT (the new transaction waits for idle).
    - Winner different, or no request with PARK_DEV ≠ owner → SWITCH.
    - No request with PARK_DEV == owner → PARK.
    - bus_busy drops in the same cycle as the state change.
- Simultaneous events: a timeout and frame_n low in the same GRANT cycle → FRAME# wins (no timeout).
- req_n changes during BUSY do not affect gnt_n until FRAME# deasserts.
- All outputs are registered; gnt_n changes one cycle after the sampled cause.

Test Plan:
- (NUM_DEV=3, PARK_DEV=0, GNT_TIMEOUT=4 throughout.)
- Reset: pulse areset, req_n = 111 → gnt_n = 111 during reset; one cycle later 111 (SWITCH); next cycle 110 with owner = 0.
- Parked device requests: from PARK, req_n = 110 → gnt_n stays 110 with no all-ones cycle; frame_n low → bus_busy = 1, rr_ptr = 1.
- Handover: req_n = 001 from PARK → gnt_n 111 for one cycle, then 101 (owner = 1). Device 1 runs FRAME# low for 3 cycles. On frame_n high → 111, then 011 (owner = 2).
- Timeout: device 2 granted, bus idle, no FRAME# for 4 cycles → timeout pulses once, gnt_n 111, next winner granted (or park 110 if req_n = 111).
- Mid-transaction reset: assert areset while bus_busy = 1 → gnt_n = 111 and bus_busy = 0 immediately, before the next clock edge.
- Fairness: req_n held 000 with each master doing one 2-phase transaction → grant order 0, 1, 2, 0, 1 with one all-ones cycle between each.

Source files
------------

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant over active-low requests, with
// one dead cycle on every grant handover, bus parking and grant timeout.
module pci_arbiter #(
    parameter int unsigned NUM_DEV     = 3,
    parameter int unsigned OWNER_W     = 2,
    parameter int unsigned PARK_DEV    = 0,
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               areset,
    input  logic [NUM_DEV-1:0] req_n,
    input  logic               frame_n,
    input  logic               irdy_n,
    output logic [NUM_DEV-1:0] gnt_n,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_busy,
    output logic               timeout
);

    typedef enum logic [1:0] {StSwitch, StPark, StGrant, StBusy} state_e;

    localparam int unsigned TimerW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [OWNER_W-1:0] ParkIdx = OWNER_W'(PARK_DEV);
    localparam logic [OWNER_W-1:0] LastIdx = OWNER_W'(NUM_DEV - 1);
    localparam logic [TimerW-1:0]  TimerMax = TimerW'(GNT_TIMEOUT);

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [NUM_DEV-1:0]   gnt_n_q, gnt_n_d;
    logic                 bus_busy_q, bus_busy_d;
    logic                 timeout_q, timeout_d;

    logic                 any_req;
    logic [OWNER_W-1:0]   winner;
    logic [OWNER_W-1:0]   idx;
    int                   idx_int;
    logic [OWNER_W-1:0]   owner_inc;
    logic [TimerW-1:0]    timer_inc;
    logic                 bus_idle;

    assign bus_idle  = frame_n & irdy_n;
    assign owner_inc = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
    assign timer_inc = timer_q + 1'b1;

    // First low request searching upward from rr_ptr, wrapping at NUM_DEV.
    always_comb begin
        any_req = 1'b0;
        winner  = ParkIdx;
        idx     = '0;
        idx_int = 0;
        for (int i = 0; i < NUM_DEV; i++) begin
            idx_int = int'(rr_ptr_q) + i;
            if (idx_int >= int'(NUM_DEV)) begin
                idx_int = idx_int - int'(NUM_DEV);
            end
            idx = OWNER_W'(idx_int);
            if (!any_req && !req_n[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StSwitch: begin
                timer_d = '0;
                if (any_req) begin
                    state_d = StGrant;
                    owner_d = winner;
                end else begin
                    state_d = StPark;
                    owner_d = ParkIdx;
                end
            end
            StPark: begin
                timer_d = '0;
                if (!frame_n) begin
                    state_d  = StBusy;
                    rr_ptr_d = owner_inc;
                end else if (any_req) begin
                    state_d = (winner == ParkIdx) ? StGrant : StSwitch;
                end
            end
            StGrant: begin
                // FRAME# takes priority over an expiring timer.
                if (!frame_n) begin
                    state_d  = StBusy;
                    rr_ptr_d = owner_inc;
                    timer_d  = '0;
                end else if (bus_idle && timer_inc == TimerMax) begin
                    state_d   = StSwitch;
                    timeout_d = 1'b1;
                    rr_ptr_d  = owner_inc;
                    timer_d   = '0;
                end else if (req_n[owner_q]) begin
                    timer_d = '0;
                    state_d = (!any_req && owner_q == ParkIdx) ? StPark : StSwitch;
                end else if (bus_idle) begin
                    timer_d = timer_inc;
                end
            end
            StBusy: begin
                timer_d = '0;
                if (frame_n) begin
                    if (any_req) begin
                        state_d = (winner == owner_q) ? StGrant : StSwitch;
                    end else begin
                        state_d = (owner_q == ParkIdx) ? StPark : StSwitch;
                    end
                end
            end
            default: state_d = StSwitch;
        endcase

        // Outputs are registered copies of the next state.
        gnt_n_d = '1;
        if (state_d != StSwitch) begin
            gnt_n_d[owner_d] = 1'b0;
        end
        bus_busy_d = (state_d == StBusy);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= StSwitch;
            owner_q    <= ParkIdx;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            gnt_n_q    <= '1;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            gnt_n_q    <= gnt_n_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_n    = gnt_n_q;
    assign owner    = owner_q;
    assign bus_busy = bus_busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter with NUM_DEV=3, PARK_DEV=0, GNT_TIMEOUT=4.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic [2:0] req_n = 3'b111;
    logic       frame_n = 1'b1;
    logic       irdy_n = 1'b1;
    logic [2:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    pci_arbiter #(
        .NUM_DEV    (3),
        .OWNER_W    (2),
        .PARK_DEV   (0),
        .GNT_TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .req_n   (req_n),
        .frame_n (frame_n),
        .irdy_n  (irdy_n),
        .gnt_n   (gnt_n),
        .owner   (owner),
        .bus_busy(bus_busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one clock through SWITCH into PARK.
    task automatic go_park();
        areset  = 1'b1;
        req_n   = 3'b111;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        req_n  = 3'b111;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b111) begin
            n_bad++; $display("FAIL reset_gnt: got %b want 111", gnt_n);
        end
        n_cmp++;
        if (owner !== 2'd0) begin
            n_bad++; $display("FAIL reset_owner: got %0d want 0", owner);
        end
        n_cmp++;
        if (bus_busy !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got busy=%b to=%b want 0 0", bus_busy, timeout);
        end
        areset = 1'b0;
        #1;
        n_cmp++;
        if (gnt_n !== 3'b111) begin
            n_bad++; $display("FAIL reset_switch: got %b want 111", gnt_n);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 3'b110 || owner !== 2'd0) begin
            n_bad++; $display("FAIL reset_park: got gnt=%b owner=%0d want 110 0", gnt_n, owner);
        end
    endtask

    task automatic test_parked_request();
        go_park();
        req_n = 3'b110;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b110) begin
            n_bad++; $display("FAIL park_grant: got %b want 110", gnt_n);
        end
        frame_n = 1'b0;
        tick();
        n_cmp++;
        if (bus_busy !== 1'b1 || gnt_n !== 3'b110) begin
            n_bad++; $display("FAIL park_busy: got busy=%b gnt=%b want 1 110", bus_busy, gnt_n);
        end
        // rr_ptr now 1: all requesting must pick device 1 next.
        frame_n = 1'b1;
        req_n   = 3'b000;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b111 || bus_busy !== 1'b0) begin
            n_bad++; $display("FAIL park_end: got gnt=%b busy=%b want 111 0", gnt_n, bus_busy);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 3'b101 || owner !== 2'd1) begin
            n_bad++; $display("FAIL park_rrptr: got gnt=%b owner=%0d want 101 1", gnt_n, owner);
        end
    endtask

    task automatic test_handover();
        go_park();
        req_n = 3'b001;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b111) begin
            n_bad++; $display("FAIL ho_switch: got %b want 111", gnt_n);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 3'b101 || owner !== 2'd1) begin
            n_bad++; $display("FAIL ho_grant1: got gnt=%b owner=%0d want 101 1", gnt_n, owner);
        end
        frame_n = 1'b0;
        tick();
        req_n = 3'b011;
        tick();
        tick();
        n_cmp++;
        if (gnt_n !== 3'b101 || bus_busy !== 1'b1) begin
            n_bad++; $display("FAIL ho_busy_hold: got gnt=%b busy=%b want 101 1", gnt_n, bus_busy);
        end
        frame_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b111 || bus_busy !== 1'b0) begin
            n_bad++; $display("FAIL ho_release: got gnt=%b busy=%b want 111 0", gnt_n, bus_busy);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 3'b011 || owner !== 2'd2) begin
            n_bad++; $display("FAIL ho_grant2: got gnt=%b owner=%0d want 011 2", gnt_n, owner);
        end
    endtask

    // Continues from test_handover: device 2 granted, bus idle.
    task automatic test_timeout();
        tick();
        tick();
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || gnt_n !== 3'b011) begin
            n_bad++; $display("FAIL to_early: got to=%b gnt=%b want 0 011", timeout, gnt_n);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1 || gnt_n !== 3'b111) begin
            n_bad++; $display("FAIL to_pulse: got to=%b gnt=%b want 1 111", timeout, gnt_n);
        end
        req_n = 3'b111;
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || gnt_n !== 3'b110 || owner !== 2'd0) begin
            n_bad++;
            $display("FAIL to_park: got to=%b gnt=%b owner=%0d want 0 110 0", timeout, gnt_n, owner);
        end
    endtask

    task automatic test_frame_wins();
        go_park();
        req_n = 3'b101;
        tick();
        tick();
        tick();
        tick();
        tick();
        frame_n = 1'b0;
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || bus_busy !== 1'b1 || gnt_n !== 3'b101) begin
            n_bad++;
            $display("FAIL fw_busy: got to=%b busy=%b gnt=%b want 0 1 101", timeout, bus_busy, gnt_n);
        end
        frame_n = 1'b1;
        req_n   = 3'b111;
        tick();
        tick();
        n_cmp++;
        if (gnt_n !== 3'b110 || owner !== 2'd0) begin
            n_bad++; $display("FAIL fw_park: got gnt=%b owner=%0d want 110 0", gnt_n, owner);
        end
    endtask

    task automatic test_req_drop();
        go_park();
        req_n = 3'b011;
        tick();
        tick();
        req_n = 3'b111;
        tick();
        n_cmp++;
        if (gnt_n !== 3'b111 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL drop_switch: got gnt=%b to=%b want 111 0", gnt_n, timeout);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 3'b110) begin
            n_bad++; $display("FAIL drop_park: got %b want 110", gnt_n);
        end
    endtask

    task automatic test_mid_reset();
        go_park();
        frame_n = 1'b0;
        tick();
        n_cmp++;
        if (bus_busy !== 1'b1) begin
            n_bad++; $display("FAIL mr_busy: got %b want 1", bus_busy);
        end
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if (gnt_n !== 3'b111 || bus_busy !== 1'b0) begin
            n_bad++; $display("FAIL mr_async: got gnt=%b busy=%b want 111 0", gnt_n, bus_busy);
        end
        frame_n = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    task automatic test_fairness();
        logic [1:0] exp_own [5];
        logic [2:0] exp_gnt;
        exp_own = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        go_park();
        req_n = 3'b000;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 3'b111;
            exp_gnt[exp_own[k]] = 1'b0;
            n_cmp++;
            if (gnt_n !== exp_gnt || owner !== exp_own[k]) begin
                n_bad++;
                $display("FAIL fair_grant%0d: got gnt=%b owner=%0d want %b %0d",
                         k, gnt_n, owner, exp_gnt, exp_own[k]);
            end
            frame_n = 1'b0;
            tick();
            tick();
            frame_n = 1'b1;
            tick();
            n_cmp++;
            if (gnt_n !== 3'b111) begin
                n_bad++; $display("FAIL fair_gap%0d: got %b want 111", k, gnt_n);
            end
            tick();
        end
        req_n = 3'b111;
    endtask

    initial begin
        test_reset();
        test_parked_request();
        test_handover();
        test_timeout();
        test_frame_wins();
        test_req_drop();
        test_mid_reset();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
